// File: rtl/bptc_xor_pipe.sv
// bptc_xor_pipe: two-stage flop-bounded XOR datapath.
// NCH lanes of W bits share one pin word. Stage 1 registers the incoming
// word (data, pin, mode). Stage 2 registers the combined lane results.
// A valid/ready handshake with backpressure joins the stages, and each
// lane keeps an XOR accumulator that is used by the ACC mode.
module bptc_xor_pipe #(
  parameter int NCH = 2,
  parameter int W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*W-1:0]  d_in,
  input  logic [W-1:0]      pin_in,
  input  logic [1:0]        mode,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*W-1:0]  pout
);

  localparam int DW = NCH * W;

  typedef enum logic [1:0] {
    MODE_XORPIN = 2'd0,
    MODE_ADJ    = 2'd1,
    MODE_ACC    = 2'd2,
    MODE_PASS   = 2'd3
  } mode_e;

  // Stage-1 registers
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [W-1:0]  s1_pin_q,  s1_pin_d;
  mode_e         s1_mode_q, s1_mode_d;
  logic          s1_valid_q, s1_valid_d;

  // Stage-2 registers and accumulators
  logic [DW-1:0] pout_q, pout_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] acc_q, acc_d;

  // Held low through reset and set by the first clock edge after release,
  // so the block only starts accepting once reset has left the clk domain.
  logic          rdy_en_q, rdy_en_d;

  // Handshake and datapath intermediates
  logic          adv;
  logic          in_xfer;
  logic          out_xfer;
  logic [DW-1:0] pin_rep;
  logic [DW-1:0] acc_base;
  logic [DW-1:0] acc_upd;
  logic [DW-1:0] adj_word;
  logic [DW-1:0] lane_res;

  // Handshake: stage 2 advances when it is empty or being drained; the
  // input side is ready whenever stage 1 is empty or moving forward.
  always_comb begin
    adv      = s1_valid_q & (~out_valid_q | out_ready);
    in_ready = rdy_en_q & (~s1_valid_q | adv);
    in_xfer  = in_valid & in_ready;
    out_xfer = out_valid_q & out_ready;
  end

  // Stage-1 next state: capture a new word on transfer, otherwise empty
  // out once the held word has moved into stage 2.
  always_comb begin
    s1_data_d  = s1_data_q;
    s1_pin_d   = s1_pin_q;
    s1_mode_d  = s1_mode_q;
    s1_valid_d = s1_valid_q;
    rdy_en_d   = 1'b1;
    if (in_xfer) begin
      s1_data_d  = d_in;
      s1_pin_d   = pin_in;
      s1_mode_d  = mode_e'(mode);
      s1_valid_d = 1'b1;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Lane functions. A clear arriving together with an ACC word makes the
  // word start from a zero accumulator. ADJ pairs each lane with its upper
  // neighbour, wrapping the top lane onto lane 0 (with one lane this
  // pairs the lane with itself and yields zero).
  always_comb begin
    pin_rep  = {NCH{s1_pin_q}};
    acc_base = acc_clr ? '0 : acc_q;
    acc_upd  = acc_base ^ s1_data_q ^ pin_rep;
    adj_word = '0;
    for (int i = 0; i < NCH; i++) begin
      adj_word[i*W +: W] = s1_data_q[i*W +: W] ^ s1_data_q[((i + 1) % NCH)*W +: W];
    end
    case (s1_mode_q)
      MODE_XORPIN: lane_res = s1_data_q ^ pin_rep;
      MODE_ADJ:    lane_res = adj_word;
      MODE_ACC:    lane_res = acc_upd;
      MODE_PASS:   lane_res = s1_data_q;
      default:     lane_res = s1_data_q;
    endcase
  end

  // Stage-2 and accumulator next state: load a result on advance, drop
  // valid after a plain output transfer, and only let ACC words (or a
  // clear) touch the accumulators.
  always_comb begin
    pout_d      = pout_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_clr ? '0 : acc_q;
    if (adv) begin
      pout_d      = lane_res;
      out_valid_d = 1'b1;
      if (s1_mode_q == MODE_ACC) begin
        acc_d = acc_upd;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // All state registers; reset empties the pipe and zeroes every value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q   <= '0;
      s1_pin_q    <= '0;
      s1_mode_q   <= MODE_XORPIN;
      s1_valid_q  <= 1'b0;
      pout_q      <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_pin_q    <= s1_pin_d;
      s1_mode_q   <= s1_mode_d;
      s1_valid_q  <= s1_valid_d;
      pout_q      <= pout_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign pout      = pout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bptc_xor_pipe.sv
// Testbench for bptc_xor_pipe with NCH=4, W=8: fixed vectors, hand-written
// handshake/accumulator/reset sequences, and a randomized run checked
// against a queue-based reference model.
module tb_bptc_xor_pipe;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DW  = NCH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d_in;
  logic [W-1:0]  pin_in;
  logic [1:0]    mode;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] pout;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct {
    logic [1:0]    m;
    logic [DW-1:0] d;
    logic [W-1:0]  p;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]    m;
    logic [DW-1:0] d;
    logic [W-1:0]  p;
  } word_t;

  vec_t vecs[6];

  // Reference model state
  word_t         m_s1[$];
  logic          m_out_full;
  logic [DW-1:0] m_out_val;
  logic [W-1:0]  m_acc[NCH];
  int            delivered;

  bptc_xor_pipe #(.NCH(NCH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .pin_in    (pin_in),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pout      (pout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [DW-1:0] d,
                               input logic [W-1:0] p, input logic clr, input logic ordy);
    in_valid  = v;
    mode      = m;
    d_in      = d;
    pin_in    = p;
    acc_clr   = clr;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Lane-level reference: each lane is computed from the mode rules with
  // plain XOR and modulo indexing over an array of lane values.
  task automatic model_process(input word_t w, output logic [DW-1:0] res);
    logic [W-1:0] ln[NCH];
    logic [W-1:0] r;
    for (int i = 0; i < NCH; i++) ln[i] = w.d[i*W +: W];
    res = '0;
    for (int i = 0; i < NCH; i++) begin
      case (w.m)
        2'd0: r = ln[i] ^ w.p;
        2'd1: r = ln[i] ^ ln[(i + 1) % NCH];
        2'd2: begin
          m_acc[i] = m_acc[i] ^ ln[i] ^ w.p;
          r = m_acc[i];
        end
        default: r = ln[i];
      endcase
      res[i*W +: W] = r;
    end
  endtask

  initial begin
    logic [W-1:0]  acc_vals[5];
    logic [DW-1:0] acc_exp[5];
    logic          s1_full, m_adv, m_rdy;
    word_t         w;
    logic [DW-1:0] res;

    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);

    // Reset state
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_pout", pout, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready_early", in_ready, 0);
    tick();
    checkOutput("rel_in_ready", in_ready, 1);

    // Fixed single-word vectors
    vecs[0] = '{m: 2'd0, d: 32'h08040201, p: 8'hFF, exp: 32'hF7FBFDFE};
    vecs[1] = '{m: 2'd1, d: 32'h08040201, p: 8'h00, exp: 32'h090C0603};
    vecs[2] = '{m: 2'd3, d: 32'hDEADBEEF, p: 8'h55, exp: 32'hDEADBEEF};
    vecs[3] = '{m: 2'd0, d: 32'h00000001, p: 8'h01, exp: 32'h01010100};
    vecs[4] = '{m: 2'd1, d: 32'hFF000000, p: 8'hA5, exp: 32'hFFFF0000};
    vecs[5] = '{m: 2'd0, d: 32'h12345678, p: 8'h00, exp: 32'h12345678};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].m, vecs[i].d, vecs[i].p, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("tbl%0d_in_ready", i), in_ready, 1);
      tick();
      applyStimulus(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("tbl%0d_latency", i), out_valid, 0);
      tick();
      checkOutput($sformatf("tbl%0d_out_valid", i), out_valid, 1);
      checkOutput($sformatf("tbl%0d_pout", i), pout, vecs[i].exp);
      tick();
    end

    // Accumulator stream, back to back, with a clear landing on the last word
    do_reset();
    acc_vals = '{8'h03, 8'h05, 8'h06, 8'h0A, 8'h09};
    acc_exp  = '{32'h0, 32'h3, 32'h6, 32'h0, 32'hA};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd2, {24'h0, acc_vals[i]}, 8'h00, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("acc%0d_in_ready", i), in_ready, 1);
      tick();
      if (i == 0) checkOutput("acc_first_latency", out_valid, 0);
      else begin
        checkOutput($sformatf("acc%0d_out_valid", i), out_valid, 1);
        checkOutput($sformatf("acc%0d_pout", i), pout, acc_exp[i]);
      end
    end
    applyStimulus(1'b0, 2'd2, '0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("acc_clr_pout", pout, 32'h9);
    checkOutput("acc_clr_out_valid", out_valid, 1);
    applyStimulus(1'b0, 2'd2, '0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("acc_drained", out_valid, 0);

    // Backpressure: three words against a stalled output
    do_reset();
    applyStimulus(1'b1, 2'd3, 32'h11111111, 8'h00, 1'b0, 1'b0);
    #1 checkOutput("bp_ready1", in_ready, 1);
    tick();
    checkOutput("bp_ov1", out_valid, 0);
    applyStimulus(1'b1, 2'd3, 32'h22222222, 8'h00, 1'b0, 1'b0);
    #1 checkOutput("bp_ready2", in_ready, 1);
    tick();
    checkOutput("bp_ov2", out_valid, 1);
    checkOutput("bp_pout2", pout, 32'h11111111);
    applyStimulus(1'b1, 2'd3, 32'h33333333, 8'h00, 1'b0, 1'b0);
    #1 checkOutput("bp_ready3", in_ready, 0);
    tick();
    checkOutput("bp_hold_pout", pout, 32'h11111111);
    #1 checkOutput("bp_ready4", in_ready, 0);
    tick();
    checkOutput("bp_hold_ov", out_valid, 1);
    checkOutput("bp_hold_pout2", pout, 32'h11111111);
    applyStimulus(1'b1, 2'd3, 32'h33333333, 8'h00, 1'b0, 1'b1);
    #1 checkOutput("bp_release_ready", in_ready, 1);
    tick();
    checkOutput("bp_word2", pout, 32'h22222222);
    applyStimulus(1'b0, 2'd3, '0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("bp_word3", pout, 32'h33333333);
    checkOutput("bp_word3_ov", out_valid, 1);
    tick();
    checkOutput("bp_empty", out_valid, 0);

    // Reset in the middle of a stalled stream
    do_reset();
    applyStimulus(1'b1, 2'd2, 32'h0F0F0F0F, 8'h33, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 32'h44444444, 8'h11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 8'h00, 1'b0, 1'b1);
    checkOutput("mid_ov_before", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ov", out_valid, 0);
    checkOutput("mid_rst_pout", pout, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("mid_no_leftover", out_valid, 0);
    applyStimulus(1'b1, 2'd2, 32'h00000001, 8'h00, 1'b0, 1'b1);
    #1 checkOutput("mid_ready", in_ready, 1);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 8'h00, 1'b0, 1'b1);
    checkOutput("mid_latency", out_valid, 0);
    tick();
    checkOutput("mid_new_ov", out_valid, 1);
    checkOutput("mid_new_pout", pout, 32'h00000001);
    tick();

    // Randomized traffic against the reference model
    do_reset();
    m_s1.delete();
    m_out_full = 1'b0;
    m_out_val  = '0;
    for (int i = 0; i < NCH; i++) m_acc[i] = '0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("rnd_out_valid", out_valid, m_out_full);
      if (m_out_full) checkOutput("rnd_pout", pout, m_out_val);
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), DW'($urandom),
                    W'($urandom_range(0, 255)), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0);
      s1_full = (m_s1.size() != 0);
      m_adv   = s1_full && (!m_out_full || out_ready);
      m_rdy   = !s1_full || m_adv;
      #1 checkOutput("rnd_in_ready", in_ready, m_rdy);
      w = '{m: mode, d: d_in, p: pin_in};
      @(posedge clk);
      if (acc_clr) for (int i = 0; i < NCH; i++) m_acc[i] = '0;
      if (m_out_full && out_ready) delivered++;
      if (m_adv) begin
        model_process(m_s1.pop_front(), res);
        m_out_val  = res;
        m_out_full = 1'b1;
      end else if (m_out_full && out_ready) begin
        m_out_full = 1'b0;
      end
      if (in_valid && m_rdy) m_s1.push_back(w);
      @(negedge clk);
    end
    $display("[TB] random phase delivered %0d words", delivered);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
